// File: rtl/matrix_store_ctrl.sv
// Slot allocator and fill sequencer for the matrix RAM, sharing the RAM port with compute-engine reads.
// Optional: define STORE_OVERWRITE_EN to recycle the oldest committed slot when every slot is valid.
module matrix_store_ctrl #(
    parameter int SLOTS  = 4,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 8,
    localparam int SLOT_W = $clog2(SLOTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_start,
    input  logic [2:0]              in_dim_m,
    input  logic [2:0]              in_dim_n,
    input  logic                    in_we,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_done,
    input  logic                    rd_req,
    input  logic [SLOT_W-1:0]       rd_id,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic                    mem_we,
    output logic [SLOT_W+IDX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    rd_ack,
    output logic                    rd_err,
    output logic [2:0]              rd_dim_m,
    output logic [2:0]              rd_dim_n,
    output logic [SLOTS-1:0]        slot_valid,
    output logic                    busy,
    output logic                    commit_valid,
    output logic [SLOT_W-1:0]       commit_id,
    output logic                    err
);

    // state  | meaning
    // IDLE   | waiting for in_start
    // ALLOC  | pick a slot, invalidate it, clear the element count
    // FILL   | accept element strobes until in_done (or abort via in_start)
    // COMMIT | mark slot valid, store dims, pulse commit_valid
    // ERR    | pulse err, drop back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_ALLOC, S_FILL, S_COMMIT, S_ERR} state_t;

    state_t state_q, state_d;

    logic [SLOT_W-1:0] cur_slot_q;
    logic [IDX_W-1:0]  elem_cnt_q, cnt_nxt;
    logic [2:0]        m_q, n_q;
    logic              got_we_q, ovf_q;
    logic [2:0]        dim_m_tab [SLOTS];
    logic [2:0]        dim_n_tab [SLOTS];
    logic [SLOT_W-1:0] commit_id_q;
`ifdef STORE_OVERWRITE_EN
    logic [SLOT_W-1:0] victim_q;
`endif

    logic              free_found;
    logic [SLOT_W-1:0] free_idx, alloc_slot;
    logic              alloc_ok, latch_dims, cnt_inc, ovf_set, abort, ovf_nxt;
    logic [2:0]        eff_m, eff_n;
    logic              dims_ok;
    logic [IDX_W-1:0]  fill_total, rd_total;

    // Dims come from the live inputs until the first element latches them.
    assign eff_m      = got_we_q ? m_q : in_dim_m;
    assign eff_n      = got_we_q ? n_q : in_dim_n;
    assign dims_ok    = (eff_m != 3'd0) && (eff_m <= 3'd5) && (eff_n != 3'd0) && (eff_n <= 3'd5);
    assign fill_total = IDX_W'(eff_m) * IDX_W'(eff_n);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_we     = 1'b0;
        alloc_ok   = 1'b0;
        alloc_slot = free_idx;
        latch_dims = 1'b0;
        cnt_inc    = 1'b0;
        ovf_set    = 1'b0;
        abort      = 1'b0;
        cnt_nxt    = elem_cnt_q;
        ovf_nxt    = ovf_q;
        case (state_q)
            S_IDLE: if (in_start) state_d = S_ALLOC;
            S_ALLOC: begin
                if (free_found) begin
                    alloc_ok = 1'b1;
                    state_d  = S_FILL;
                end else begin
`ifdef STORE_OVERWRITE_EN
                    alloc_ok   = 1'b1;
                    alloc_slot = victim_q;
                    state_d    = S_FILL;
`else
                    state_d = S_ERR;
`endif
                end
            end
            S_FILL: begin
                if (in_start) begin
                    abort   = 1'b1;
                    state_d = S_ALLOC;
                end else if (in_we && !got_we_q && !dims_ok) begin
                    state_d = S_ERR;
                end else begin
                    if (in_we) begin
                        latch_dims = !got_we_q;
                        if (elem_cnt_q < fill_total) begin
                            mem_we  = 1'b1;
                            cnt_inc = 1'b1;
                            cnt_nxt = elem_cnt_q + IDX_W'(1);
                        end else begin
                            ovf_set = 1'b1;
                            ovf_nxt = 1'b1;
                        end
                    end
                    // Count check sees this cycle's element, if any.
                    if (in_done) begin
                        if ((got_we_q || in_we) && (cnt_nxt == fill_total) && !ovf_nxt)
                            state_d = S_COMMIT;
                        else
                            state_d = S_ERR;
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_slot_q  <= '0;
            elem_cnt_q  <= '0;
            m_q         <= '0;
            n_q         <= '0;
            got_we_q    <= 1'b0;
            ovf_q       <= 1'b0;
            slot_valid  <= '0;
            commit_id_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                dim_m_tab[i] <= '0;
                dim_n_tab[i] <= '0;
            end
`ifdef STORE_OVERWRITE_EN
            victim_q <= '0;
`endif
        end else begin
            if (alloc_ok) begin
                cur_slot_q             <= alloc_slot;
                slot_valid[alloc_slot] <= 1'b0;
                elem_cnt_q             <= '0;
                got_we_q               <= 1'b0;
                ovf_q                  <= 1'b0;
            end
            if (latch_dims) begin
                m_q      <= in_dim_m;
                n_q      <= in_dim_n;
                got_we_q <= 1'b1;
            end
            if (cnt_inc) elem_cnt_q <= cnt_nxt;
            if (ovf_set) ovf_q <= 1'b1;
            if (state_q == S_COMMIT) begin
                slot_valid[cur_slot_q] <= 1'b1;
                dim_m_tab[cur_slot_q]  <= m_q;
                dim_n_tab[cur_slot_q]  <= n_q;
                commit_id_q            <= cur_slot_q;
`ifdef STORE_OVERWRITE_EN
                victim_q <= (cur_slot_q == SLOT_W'(SLOTS - 1)) ? '0 : cur_slot_q + SLOT_W'(1);
`endif
            end
        end
    end

    // Writes own the RAM port; a pending read simply waits for a free cycle.
    assign rd_ack    = rd_req && !mem_we;
    assign mem_addr  = mem_we ? {cur_slot_q, elem_cnt_q} : (rd_req ? {rd_id, rd_idx} : '0);
    assign mem_wdata = mem_we ? in_data : '0;

    assign rd_dim_m = dim_m_tab[rd_id];
    assign rd_dim_n = dim_n_tab[rd_id];
    assign rd_total = IDX_W'(rd_dim_m) * IDX_W'(rd_dim_n);
    assign rd_err   = rd_ack && (!slot_valid[rd_id] || (rd_idx >= rd_total));

    assign busy         = (state_q != S_IDLE);
    assign commit_valid = (state_q == S_COMMIT);
    assign commit_id    = commit_valid ? cur_slot_q : commit_id_q;
    assign err          = (state_q == S_ERR) || abort;

endmodule

// File: tb/tb_matrix_store_ctrl.sv
// Directed bench for matrix_store_ctrl: stimulus pushes expected RAM writes, read acks, commits and
// error pulses into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_matrix_store_ctrl;
    localparam int SLOTS = 4, IDX_W = 5, DATA_W = 8, SLOT_W = 2;

    logic clk = 1'b0;
    logic rst, in_start, in_we, in_done, rd_req;
    logic [2:0] in_dim_m, in_dim_n;
    logic [DATA_W-1:0] in_data;
    logic [SLOT_W-1:0] rd_id;
    logic [IDX_W-1:0] rd_idx;
    logic mem_we, rd_ack, rd_err, busy, commit_valid, err;
    logic [SLOT_W+IDX_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0] rd_dim_m, rd_dim_n;
    logic [SLOTS-1:0] slot_valid;
    logic [SLOT_W-1:0] commit_id;

    int checks = 0;
    int failures = 0;
    int wr_q[$];
    int rd_q[$];
    int cm_q[$];
    int er_q[$];

    matrix_store_ctrl #(.SLOTS(SLOTS), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_dim_m(in_dim_m), .in_dim_n(in_dim_n),
        .in_we(in_we), .in_data(in_data), .in_done(in_done), .rd_req(rd_req), .rd_id(rd_id),
        .rd_idx(rd_idx), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_ack(rd_ack), .rd_err(rd_err), .rd_dim_m(rd_dim_m), .rd_dim_n(rd_dim_n),
        .slot_valid(slot_valid), .busy(busy), .commit_valid(commit_valid),
        .commit_id(commit_id), .err(err)
    );

    always #5 clk = ~clk;

    task automatic note(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        note(act == exp, name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wr_q.size() == 0) note(1'b0, "unexpected_write", int'({mem_addr, mem_wdata}), 0);
                else chk("write_addr_data", int'({mem_addr, mem_wdata}), wr_q.pop_front());
            end
            if (rd_ack) begin
                if (rd_q.size() == 0) note(1'b0, "unexpected_rd_ack", int'({mem_addr, rd_err}), 0);
                else chk("rd_addr_err", int'({mem_addr, rd_err}), rd_q.pop_front());
            end
            if (commit_valid) begin
                if (cm_q.size() == 0) note(1'b0, "unexpected_commit", int'(commit_id), 0);
                else chk("commit_id", int'(commit_id), cm_q.pop_front());
            end
            if (err) begin
                if (er_q.size() == 0) note(1'b0, "unexpected_err", 1, 0);
                else chk("err_pulse", 1, er_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in FILL (or ERR when allocation fails).
    task automatic start_matrix(input int m, input int n);
        in_dim_m = 3'(m);
        in_dim_n = 3'(n);
        in_start = 1'b1;
        cyc();
        in_start = 1'b0;
        cyc();
    endtask

    task automatic wr(input int slot, input int idx, input int data, input bit expect_wr);
        in_we   = 1'b1;
        in_data = 8'(data);
        if (expect_wr) wr_q.push_back(((slot << IDX_W | idx) << 8) | data);
        cyc();
        in_we = 1'b0;
    endtask

    task automatic finish_matrix(input bit commit, input int id);
        in_done = 1'b1;
        if (commit) cm_q.push_back(id);
        else er_q.push_back(1);
        cyc();
        in_done = 1'b0;
        cyc();
    endtask

    // Single-element matrix with in_we and in_done in the same cycle.
    task automatic one_shot(input int slot, input int data);
        in_dim_m = 3'd1;
        in_dim_n = 3'd1;
        in_we    = 1'b1;
        in_done  = 1'b1;
        in_data  = 8'(data);
        wr_q.push_back(((slot << IDX_W) << 8) | data);
        cm_q.push_back(slot);
        cyc();
        in_we   = 1'b0;
        in_done = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; in_start = 0; in_we = 0; in_done = 0; rd_req = 0;
        in_dim_m = 0; in_dim_n = 0; in_data = 0; rd_id = 0; rd_idx = 0;
        repeat (2) cyc();
        rst = 1'b0;
        chk("reset_slot_valid", int'(slot_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_mem_we", int'(mem_we), 0);
        chk("reset_commit_id", int'(commit_id), 0);
        chk("reset_dim_m", int'(rd_dim_m), 0);

        // 2x3 matrix into slot 0
        start_matrix(2, 3);
        for (int k = 0; k < 6; k++) wr(0, k, k + 1, 1'b1);
        finish_matrix(1'b1, 0);
        chk("t1_slot_valid", int'(slot_valid), 4'b0001);
        rd_id = 2'd0;
        #1;
        chk("t1_rd_dim_m", int'(rd_dim_m), 2);
        chk("t1_rd_dim_n", int'(rd_dim_n), 3);

        // short count: 3 of 4 elements
        start_matrix(2, 2);
        for (int k = 0; k < 3; k++) wr(1, k, 8'h20 + k, 1'b1);
        in_done = 1'b1;
        er_q.push_back(1);
        cyc();
        in_done = 1'b0;
        chk("t2_busy_in_err", int'(busy), 1);
        cyc();
        chk("t2_busy_dropped", int'(busy), 0);
        chk("t2_slot_valid", int'(slot_valid), 4'b0001);

        // overflow: 5 strobes on a 2x2 matrix
        start_matrix(2, 2);
        for (int k = 0; k < 5; k++) wr(1, k, 8'h10 + k, k < 4);
        finish_matrix(1'b0, 0);
        chk("t3_slot_valid", int'(slot_valid), 4'b0001);

        // bad dims on first element: no write, error
        start_matrix(6, 2);
        er_q.push_back(1);
        wr(1, 0, 8'h55, 1'b0);
        cyc();
        chk("bad_dims_busy", int'(busy), 0);
        chk("bad_dims_slot_valid", int'(slot_valid), 4'b0001);

        // reads held across fill writes
        start_matrix(1, 2);
        rd_req = 1'b1; rd_id = 2'd0; rd_idx = 5'd6;
        wr(1, 0, 8'hA1, 1'b1);
        rd_q.push_back(((0 << IDX_W | 6) << 1) | 1);
        cyc();
        rd_idx = 5'd5;
        rd_q.push_back(((0 << IDX_W | 5) << 1) | 0);
        cyc();
        rd_id = 2'd1; rd_idx = 5'd0;
        rd_q.push_back(((1 << IDX_W | 0) << 1) | 1);
        cyc();
        rd_id = 2'd0; rd_idx = 5'd6;
        wr(1, 1, 8'hA2, 1'b1);
        rd_req = 1'b0;
        finish_matrix(1'b1, 1);
        chk("t5_slot_valid", int'(slot_valid), 4'b0011);
        chk("t5_commit_id_held", int'(commit_id), 1);
        rd_id = 2'd1;
        #1;
        chk("t5_rd_dim_n", int'(rd_dim_n), 2);

        // abort mid-fill, refill lands in the same lowest free slot
        start_matrix(1, 1);
        in_start = 1'b1;
        er_q.push_back(1);
        cyc();
        in_start = 1'b0;
        cyc();
        chk("t6_abort_slot_invalid", int'(slot_valid), 4'b0011);
        one_shot(2, 8'h78);
        chk("t6_slot_valid", int'(slot_valid), 4'b0111);

        // reset mid-fill
        start_matrix(1, 2);
        wr(3, 0, 8'h99, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_slot_valid", int'(slot_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rd_id = 2'd2;
        #1;
        chk("rst_dim_m", int'(rd_dim_m), 0);

        // fill all four slots, then a fifth matrix
        for (int s = 0; s < 4; s++) begin
            start_matrix(1, 1);
            one_shot(s, 8'hC0 + s);
        end
        chk("t4_full", int'(slot_valid), 4'b1111);
`ifdef STORE_OVERWRITE_EN
        start_matrix(1, 1);
        chk("t4_victim_invalid", int'(slot_valid), 4'b1110);
        one_shot(0, 8'hEE);
`else
        er_q.push_back(1);
        start_matrix(1, 1);
        in_we = 1'b1; in_data = 8'hEE;
        cyc();
        cyc();
        in_we = 1'b0;
        chk("t4_busy_after_err", int'(busy), 0);
`endif
        chk("t4_slot_valid_end", int'(slot_valid), 4'b1111);

        repeat (2) cyc();
        chk("leftover_writes", wr_q.size(), 0);
        chk("leftover_reads", rd_q.size(), 0);
        chk("leftover_commits", cm_q.size(), 0);
        chk("leftover_errs", er_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
